multiply: RTL and testbench

Sequential 16×16 shift-add multiplier for the EX stage of the 16-bit five-stage pipeline. It produces a 32-bit product, signed or unsigned, using the same start/annul/ready handshake as the iterative divider. The pipeline stalls on it exactly as it does for division. High half of the result goes to `result_o[31:16]`, low half to `result_o[15:0]`.

---
 rtl/multiply.sv | 133 +++++++++++++
 tb/tb_multiply.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiply.sv
// Iterative 16x16 shift-add multiplier for the EX stage. It produces a signed or unsigned
// 32-bit product and uses the same start/annul/ready handshake as the divider.
module multiply (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_mul_i,
  input  logic [15:0] opdata1_i,
  input  logic [15:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [31:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    MUL_FREE = 2'b00,
    MUL_ZERO = 2'b01,
    MUL_ON   = 2'b10,
    MUL_END  = 2'b11
  } state_t;

  localparam logic [4:0] LAST_ITER = 5'd16;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic        signed_q, signed_d;
  logic        sign1_q, sign1_d;
  logic        sign2_q, sign2_d;
  logic [31:0] result_d;
  logic        ready_d;

  logic [15:0] mag1, mag2;
  logic [16:0] sum;

  // In signed mode, negative operands become their magnitudes. 0x8000 negates to itself,
  // and that is still the correct unsigned magnitude.
  assign mag1 = (signed_mul_i && opdata1_i[15]) ? (~opdata1_i + 16'd1) : opdata1_i;
  assign mag2 = (signed_mul_i && opdata2_i[15]) ? (~opdata2_i + 16'd1) : opdata2_i;

  assign sum = {1'b0, acc_q[31:16]} + {1'b0, (acc_q[0] ? mcand_q : 16'h0000)};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    signed_d = signed_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    result_d = result_o;
    ready_d  = ready_o;

    unique case (state_q)
      MUL_FREE: begin
        ready_d  = 1'b0;
        result_d = 32'h0000_0000;
        if (start_i && !annul_i) begin
          signed_d = signed_mul_i;
          sign1_d  = opdata1_i[15];
          sign2_d  = opdata2_i[15];
          acc_d    = {17'h0_0000, mag2};
          mcand_d  = mag1;
          cnt_d    = 5'd0;
          if (opdata1_i == 16'h0000 || opdata2_i == 16'h0000) state_d = MUL_ZERO;
          else                                                  state_d = MUL_ON;
        end
      end

      MUL_ZERO: begin
        acc_d   = 33'h0_0000_0000;
        state_d = MUL_END;
      end

      MUL_ON: begin
        if (annul_i) begin
          state_d = MUL_FREE;
        end else if (cnt_q != LAST_ITER) begin
          acc_d = {1'b0, sum, acc_q[15:1]};
          cnt_d = cnt_q + 5'd1;
        end else begin
          // The magnitude product is negated only when exactly one signed operand was negative.
          if (signed_q && (sign1_q ^ sign2_q)) acc_d[31:0] = ~acc_q[31:0] + 32'd1;
          cnt_d   = 5'd0;
          state_d = MUL_END;
        end
      end

      MUL_END: begin
        result_d = acc_q[31:0];
        ready_d  = 1'b1;
        if (!start_i) begin
          result_d = 32'h0000_0000;
          ready_d  = 1'b0;
          state_d  = MUL_FREE;
        end
      end

      default: state_d = MUL_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so that every register
    // updates from values taken before the clock edge.
    if (!rst) begin
      state_q  <= MUL_FREE;
      cnt_q    <= 5'd0;
      result_o <= 32'h0000_0000;
      ready_o  <= 1'b0;
      // NOTE: the datapath registers are cleared as well. They are few, and clearing them
      // keeps the state after reset fully determined.
      acc_q    <= 33'h0_0000_0000;
      mcand_q  <= 16'h0000;
      signed_q <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_o <= result_d;
      ready_o  <= ready_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      signed_q <= signed_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
    end
  end

endmodule

// File: tb/tb_multiply.sv
// Directed bench for multiply. Each scenario task drives its own stimulus and compares
// against hand-computed products and latencies.
module tb_multiply;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_mul_i = 1'b0;
  logic [15:0] opdata1_i = 16'h0000;
  logic [15:0] opdata2_i = 16'h0000;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [31:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  multiply dut (
    .clk          (clk),
    .rst          (rst),
    .signed_mul_i (signed_mul_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and leaves start_i held. lat is the number of edges after
  // edge N until ready_o is seen, or -1 if ready_o never rises. stray is set when
  // result_o is non-zero while ready_o is low.
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                        output int lat, output logic [31:0] res, output logic stray);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_mul_i = sgn;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    lat   = -1;
    stray = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      tick();
      if (ready_o) begin
        lat = k;
        break;
      end
      if (result_o !== 32'h0) stray = 1'b1;
    end
    res = result_o;
  endtask

  task automatic drop_start();
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 32'h0) begin
      errors++;
      $display("FAIL reset: ready=%b result=%h, want 0/00000000", ready_o, result_o);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    int lat; logic [31:0] res; logic stray;
    do_mul(16'hFFFF, 16'hFFFF, 1'b0, lat, res, stray);
    checks++;
    if (lat != 18 || res !== 32'hFFFE0001 || stray) begin
      errors++;
      $display("FAIL unsigned_ffff: lat=%0d result=%h stray=%b, want 18/fffe0001/0", lat, res, stray);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ready_o !== 1'b1 || result_o !== 32'hFFFE0001) begin
        errors++;
        $display("FAIL hold_%0d: ready=%b result=%h, want 1/fffe0001", i, ready_o, result_o);
      end
    end
    drop_start();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 32'h0) begin
      errors++;
      $display("FAIL release: ready=%b result=%h, want 0/00000000", ready_o, result_o);
    end
    do_mul(16'h8000, 16'h0001, 1'b0, lat, res, stray);
    checks++;
    if (lat != 18 || res !== 32'h00008000) begin
      errors++;
      $display("FAIL unsigned_8000x1: lat=%0d result=%h, want 18/00008000", lat, res);
    end
    drop_start();
    do_mul(16'h1234, 16'h5678, 1'b0, lat, res, stray);
    checks++;
    if (lat != 18 || res !== 32'h06260060) begin
      errors++;
      $display("FAIL unsigned_1234x5678: lat=%0d result=%h, want 18/06260060", lat, res);
    end
    drop_start();
  endtask

  task automatic test_signed();
    int lat; logic [31:0] res; logic stray;
    logic [15:0] va [4] = '{16'hFFFD, 16'h8000, 16'h8000, 16'hFFFF};
    logic [15:0] vb [4] = '{16'h0007, 16'h8000, 16'h0001, 16'hFFFF};
    logic [31:0] vp [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFF8000, 32'h00000001};
    for (int i = 0; i < 4; i++) begin
      do_mul(va[i], vb[i], 1'b1, lat, res, stray);
      checks++;
      if (lat != 18 || res !== vp[i] || stray) begin
        errors++;
        $display("FAIL signed_%0d %h*%h: lat=%0d result=%h, want 18/%h", i, va[i], vb[i], lat, res, vp[i]);
      end
      drop_start();
    end
  endtask

  task automatic test_zero();
    int lat; logic [31:0] res; logic stray;
    do_mul(16'h1234, 16'h0000, 1'b0, lat, res, stray);
    checks++;
    if (lat != 2 || res !== 32'h0) begin
      errors++;
      $display("FAIL zero_op2: lat=%0d result=%h, want 2/00000000", lat, res);
    end
    drop_start();
    do_mul(16'h0000, 16'hFFFF, 1'b1, lat, res, stray);
    checks++;
    if (lat != 2 || res !== 32'h0) begin
      errors++;
      $display("FAIL zero_op1_signed: lat=%0d result=%h, want 2/00000000", lat, res);
    end
    drop_start();
  endtask

  task automatic test_annul();
    int lat; logic [31:0] res; logic stray;
    logic saw_ready = 1'b0;
    opdata1_i = 16'h0101; opdata2_i = 16'h0202; signed_mul_i = 1'b0;
    start_i = 1'b1;
    tick();                            // edge N
    for (int i = 1; i <= 4; i++) begin // edges N+1..N+4
      tick();
      if (ready_o) saw_ready = 1'b1;
    end
    annul_i = 1'b1;
    tick();                            // edge N+5
    if (ready_o) saw_ready = 1'b1;
    do_mul(16'h0003, 16'h0005, 1'b0, lat, res, stray);
    checks++;
    if (saw_ready || lat != 18 || res !== 32'h0000000F) begin
      errors++;
      $display("FAIL annul: early_ready=%b lat=%0d result=%h, want 0/18/0000000f", saw_ready, lat, res);
    end
    drop_start();
  endtask

  task automatic test_operand_change();
    int lat = -1;
    opdata1_i = 16'hFFFD; opdata2_i = 16'h0007; signed_mul_i = 1'b1;
    start_i = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      tick();
      if (ready_o) begin
        lat = k;
        break;
      end
      opdata1_i    = 16'h1357 + 16'(k * 16'h0F0F);
      opdata2_i    = 16'hC0DE ^ 16'(k);
      signed_mul_i = k[0];
    end
    checks++;
    if (lat != 18 || result_o !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL operand_change: lat=%0d result=%h, want 18/ffffffeb", lat, result_o);
    end
    drop_start();
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res; logic stray;
    opdata1_i = 16'h00FF; opdata2_i = 16'h0101; signed_mul_i = 1'b0;
    start_i = 1'b1;
    tick();                            // edge N
    for (int i = 1; i <= 9; i++) tick();
    rst = 1'b0;
    tick();                            // edge N+10
    checks++;
    if (ready_o !== 1'b0 || result_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mulon: ready=%b result=%h, want 0/00000000", ready_o, result_o);
    end
    rst = 1'b1; start_i = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_lost_op: ready=%b, want 0", ready_o);
    end
    do_mul(16'h00FF, 16'h0101, 1'b0, lat, res, stray);
    checks++;
    if (lat != 18 || res !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL after_reset_mulon: lat=%0d result=%h, want 18/0000ffff", lat, res);
    end
    rst = 1'b0;                        // reset while in MulEnd with start held
    tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mulend: ready=%b result=%h, want 0/00000000", ready_o, result_o);
    end
    start_i = 1'b0; rst = 1'b1;
    tick();
    do_mul(16'hFFFD, 16'h0007, 1'b1, lat, res, stray);
    checks++;
    if (lat != 18 || res !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL after_reset_mulend: lat=%0d result=%h, want 18/ffffffeb", lat, res);
    end
    drop_start();
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; logic stray;
    do_mul(16'h0010, 16'h0020, 1'b0, lat, res, stray);
    drop_start();                      // one idle cycle between requests
    checks++;
    if (lat != 18 || res !== 32'h00000200) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d result=%h, want 18/00000200", lat, res);
    end
    do_mul(16'hFFFE, 16'hFFFE, 1'b1, lat, res, stray);
    checks++;
    if (lat != 18 || res !== 32'h00000004) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d result=%h, want 18/00000004", lat, res);
    end
    drop_start();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero();
    test_annul();
    test_operand_change();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
